// File: rtl/odd_seq_checker.sv
// odd_seq_checker
//   Watches the output of an odd-only up/down counter (values 1,3,..,15) and
//   checks that each qualified sample is the legal successor of the previous
//   one. A three-state FSM (ACQ / LOCK / FAULT) acquires on the first odd
//   sample, tracks the sequence while locked, and latches FAULT after three
//   consecutive odd-but-wrong samples. Rejected samples pulse err and are
//   counted in a saturating 8-bit counter.
//
// Build option:
//   ODD_CHK_WRAPCNT_EN  when defined, adds the wrap_cnt output, an 8-bit
//                       modulo-256 count of wrap_up/wrap_dn pulses.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   cnt[3:0]   in   counter value under test
//   cnt_valid  in   qualifies cnt/dir for one cycle
//   dir        in   direction that produced cnt (1 = up, 0 = down)
//   clr        in   synchronous clear of err_cnt (and wrap_cnt); FAULT -> ACQ
//   locked     out  FSM is in LOCK
//   fault      out  FSM is in FAULT
//   err        out  one-cycle pulse per rejected sample
//   err_cnt    out  saturating count of rejected samples
//   wrap_up    out  one-cycle pulse on a legal 15 -> 1 step
//   wrap_dn    out  one-cycle pulse on a legal 1 -> 15 step
//   wrap_cnt   out  (ODD_CHK_WRAPCNT_EN only) count of wrap pulses, mod 256
module odd_seq_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt,
  input  logic       cnt_valid,
  input  logic       dir,
  input  logic       clr,
  output logic       locked,
  output logic       fault,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       wrap_up,
`ifdef ODD_CHK_WRAPCNT_EN
  output logic       wrap_dn,
  output logic [7:0] wrap_cnt
`else
  output logic       wrap_dn
`endif
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [1:0] miss_q, miss_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_q, err_d;
  logic       wrap_up_q, wrap_up_d;
  logic       wrap_dn_q, wrap_dn_d;
  logic [3:0] exp_cnt;
  logic       rej;
`ifdef ODD_CHK_WRAPCNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;
`endif

  // Expected successor of prev; the odd sequence wraps 15 <-> 1 explicitly.
  always_comb begin
    if (dir) exp_cnt = (prev_q == 4'd15) ? 4'd1  : prev_q + 4'd2;
    else     exp_cnt = (prev_q == 4'd1)  ? 4'd15 : prev_q - 4'd2;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ACQ;
      prev_q    <= 4'd1;
      miss_q    <= 2'd0;
      err_cnt_q <= 8'd0;
      err_q     <= 1'b0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      miss_q    <= miss_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
    end
  end

`ifdef ODD_CHK_WRAPCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_cnt_q <= 8'd0;
    else        wrap_cnt_q <= wrap_cnt_d;
  end
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    miss_d    = miss_q;
    err_cnt_d = err_cnt_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    rej       = 1'b0;

    if (clr) begin
      // clr has priority over a coincident sample, which is dropped.
      err_cnt_d = 8'd0;
      if (state_q == FAULT) state_d = ACQ;
    end else if (cnt_valid) begin
      unique case (state_q)
        ACQ: begin
          if (cnt[0]) begin
            prev_d  = cnt;
            miss_d  = 2'd0;
            state_d = LOCK;
          end else begin
            rej = 1'b1;
          end
        end
        LOCK: begin
          if (cnt == exp_cnt) begin
            prev_d    = cnt;
            miss_d    = 2'd0;
            wrap_up_d = dir  && (prev_q == 4'd15);
            wrap_dn_d = !dir && (prev_q == 4'd1);
          end else if (cnt[0]) begin
            // Odd but out of sequence: resync on it, fault on the third in a row.
            rej    = 1'b1;
            prev_d = cnt;
            miss_d = miss_q + 2'd1;
            if (miss_q == 2'd2) state_d = FAULT;
          end else begin
            rej     = 1'b1;
            state_d = ACQ;
          end
        end
        FAULT: ;
        default: state_d = ACQ;
      endcase
    end

    err_d = rej;
    if (rej && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

`ifdef ODD_CHK_WRAPCNT_EN
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clr)                          wrap_cnt_d = 8'd0;
    else if (wrap_up_d || wrap_dn_d)  wrap_cnt_d = wrap_cnt_q + 8'd1;
  end
  assign wrap_cnt = wrap_cnt_q;
`endif

  // Output logic: everything comes straight from flops.
  always_comb begin
    locked  = (state_q == LOCK);
    fault   = (state_q == FAULT);
    err     = err_q;
    err_cnt = err_cnt_q;
    wrap_up = wrap_up_q;
    wrap_dn = wrap_dn_q;
  end

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: the driver predicts each cycle's
// outputs with a behavioural model and queues them; the monitor compares the
// DUT a little after every rising edge.
module tb_odd_seq_checker;

  logic       clk;
  logic       reset;
  logic [3:0] cnt;
  logic       cnt_valid;
  logic       dir;
  logic       clr;
  logic       locked, fault, err, wrap_up, wrap_dn;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt_obs;

  odd_seq_checker dut (
    .clk       (clk),
    .reset     (reset),
    .cnt       (cnt),
    .cnt_valid (cnt_valid),
    .dir       (dir),
    .clr       (clr),
    .locked    (locked),
    .fault     (fault),
    .err       (err),
    .err_cnt   (err_cnt),
    .wrap_up   (wrap_up),
`ifdef ODD_CHK_WRAPCNT_EN
    .wrap_dn   (wrap_dn),
    .wrap_cnt  (wrap_cnt_obs)
`else
    .wrap_dn   (wrap_dn)
`endif
  );

`ifndef ODD_CHK_WRAPCNT_EN
  assign wrap_cnt_obs = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit locked, fault, err, wu, wd;
    int ec, wc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit m_locked, m_fault;
  int m_last, m_miss, m_errs, m_wraps;

  function automatic int succ(input int last, input bit d);
    return d ? (last + 2) % 16 : (last + 14) % 16;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_fault = 0; m_last = 1; m_miss = 0; m_errs = 0; m_wraps = 0;
  endtask

  task automatic model(input bit v, input int c, input bit d, input bit cl, output exp_t e);
    bit rej;
    rej = 0; e.wu = 0; e.wd = 0;
    if (cl) begin
      m_errs = 0; m_wraps = 0; m_fault = 0;
    end else if (v && !m_fault) begin
      if (!m_locked) begin
        if (c % 2 == 1) begin m_locked = 1; m_last = c; m_miss = 0; end
        else rej = 1;
      end else if (c == succ(m_last, d)) begin
        e.wu = d && (m_last == 15);
        e.wd = !d && (m_last == 1);
        if (e.wu || e.wd) m_wraps = (m_wraps + 1) % 256;
        m_last = c; m_miss = 0;
      end else if (c % 2 == 1) begin
        rej = 1; m_last = c; m_miss++;
        if (m_miss == 3) begin m_locked = 0; m_fault = 1; end
      end else begin
        rej = 1; m_locked = 0;
      end
    end
    if (rej && m_errs < 255) m_errs++;
    e.err = rej;
    e.locked = m_locked; e.fault = m_fault; e.ec = m_errs;
`ifdef ODD_CHK_WRAPCNT_EN
    e.wc = m_wraps;
`else
    e.wc = 0;
`endif
  endtask

  task automatic step(input bit v, input int c, input bit d, input bit cl);
    exp_t e;
    @(negedge clk);
    cnt_valid = v; cnt = 4'(c); dir = d; clr = cl;
    model(v, c, d, cl, e);
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if (locked !== 0 || fault !== 0 || err !== 0 || err_cnt !== 0 ||
        wrap_up !== 0 || wrap_dn !== 0 || wrap_cnt_obs !== 0) begin
      n_bad++;
      $display("FAIL %s: got lk=%b ft=%b err=%b ec=%0d wu=%b wd=%b wc=%0d, want all 0",
               name, locked, fault, err, err_cnt, wrap_up, wrap_dn, wrap_cnt_obs);
    end
  endtask

  // Monitor: outputs are presented every cycle, one cycle after the sample edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (locked !== e.locked || fault !== e.fault || err !== e.err ||
            int'(err_cnt) != e.ec || wrap_up !== e.wu || wrap_dn !== e.wd ||
            int'(wrap_cnt_obs) != e.wc) begin
          n_bad++;
          $display("FAIL cycle t=%0t: got lk=%b ft=%b err=%b ec=%0d wu=%b wd=%b wc=%0d; want lk=%b ft=%b err=%b ec=%0d wu=%b wd=%b wc=%0d",
                   $time, locked, fault, err, err_cnt, wrap_up, wrap_dn, wrap_cnt_obs,
                   e.locked, e.fault, e.err, e.ec, e.wu, e.wd, e.wc);
        end
      end
    end
  end

  initial begin
    int c;
    bit d;
    reset = 1'b0; cnt = 4'd0; cnt_valid = 1'b0; dir = 1'b0; clr = 1'b0;
    model_reset();
    #3 check_all_zero("reset_state");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Acquire and track upward, then wrap 15 -> 1.
    for (int v = 1; v <= 15; v += 2) step(1, v, 1, 0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    // Wrap 1 -> 15 downward, then walk down to 5.
    step(1, 15, 0, 0);
    for (int v = 13; v >= 5; v -= 2) step(1, v, 0, 0);
    // Three consecutive odd misses -> FAULT; later samples ignored.
    step(1, 9, 1, 0);
    step(1, 3, 1, 0);
    step(1, 11, 1, 0);
    step(1, 13, 1, 0);
    step(1, 2, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // Even sample drops LOCK -> ACQ; next odd reacquires.
    step(1, 3, 1, 0);
    step(1, 5, 1, 0);
    step(1, 4, 1, 0);
    step(1, 7, 0, 0);
    // Direction change is legal.
    step(1, 5, 0, 0);
    step(1, 7, 1, 0);
    // Saturation: 260 even samples in ACQ.
    for (int i = 0; i < 260; i++) step(1, 2 * (i % 8), i % 2, 0);
    step(1, 6, 0, 0);
    step(1, 8, 1, 1);
    step(0, 0, 0, 0);

    // Randomized: mostly legal successors with occasional disruptions.
    for (int i = 0; i < 3000; i++) begin
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7)
        c = m_locked ? succ(m_last, d) : 2 * $urandom_range(0, 7) + 1;
      else
        c = $urandom_range(0, 15);
      step($urandom_range(0, 9) != 0, c, d, $urandom_range(0, 59) == 0);
    end

    // Reset landing between the edges of an active sample.
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    step(1, 2, 1, 0);
    @(negedge clk);
    cnt_valid = 1'b1; cnt = 4'd3; dir = 1'b1; clr = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1 check_all_zero("async_reset_mid_sample");
    @(negedge clk);
    cnt_valid = 1'b0;
    reset = 1'b1;
    step(1, 2, 1, 0);
    step(1, 3, 1, 0);
    step(1, 5, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/odd_seq_checker.md
ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock.
REQ-002 The block SHALL expose: reset  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: cnt  input  4  count value from the odd up/down counter stage.
REQ-004 The block SHALL expose: cnt_valid  input  1  qualifies cnt and dir for one cycle.
REQ-005 The block SHALL expose: dir  input  1  direction that produced cnt; 1 = up, 0 = down.
REQ-006 The block SHALL expose: clr  input  1  synchronous clear of err_cnt and FAULT state.
REQ-007 The block SHALL expose: locked  output  1  high while the FSM is in LOCK.
REQ-008 The block SHALL expose: fault  output  1  high while the FSM is in FAULT.
REQ-009 The block SHALL expose: err  output  1  one-cycle pulse per rejected sample.
REQ-010 The block SHALL expose: err_cnt  output  8  saturating count of rejected samples.
REQ-011 The block SHALL expose: wrap_up / wrap_dn  output  1 each  one-cycle pulses on a legal 15->1 or 1->15 step.

Function
REQ-012 All outputs SHALL be registered, with one-cycle latency from the sampling edge (cnt_valid=1) to the output update.
REQ-013 The FSM SHALL have exactly three states: ACQ, LOCK and FAULT.
REQ-014 ACQ, odd cnt: prev <= cnt, miss_run <= 0, -> LOCK, no err.
REQ-015 ACQ, even cnt: err pulse, err_cnt++, stay in ACQ.
REQ-016 In LOCK, exp SHALL be: dir=1 -> (prev==15 ? 1 : prev+2); dir=0 -> (prev==1 ? 15 : prev-2), using 4-bit arithmetic with explicit wrap.
REQ-017 LOCK, cnt==exp: prev <= cnt, miss_run <= 0, no err; wrap_up pulses if prev==15 && dir==1; wrap_dn pulses if prev==1 && dir==0.
REQ-018 LOCK, cnt!=exp and cnt odd: err pulse, err_cnt++, prev <= cnt (resync), miss_run++; if miss_run was 2 (third consecutive miss) -> FAULT, else stay in LOCK.
REQ-019 LOCK, cnt even: err pulse, err_cnt++, -> ACQ.
REQ-020 FAULT: samples SHALL be ignored (no err, no err_cnt change, no wrap pulses); exit only via clr -> ACQ.
REQ-021 err_cnt SHALL saturate at 255; a further rejection still pulses err but holds err_cnt at 255.
REQ-022 clr=1 SHALL set err_cnt <= 0 and move FAULT -> ACQ; in ACQ/LOCK the state SHALL be unchanged; clr together with cnt_valid SHALL discard the sample (clr wins, no pulses).
REQ-023 Cycles with cnt_valid=0 SHALL hold state, prev, miss_run and err_cnt; err/wrap pulses SHALL be 0.
REQ-024 A direction change between samples SHALL be legal; exp always uses the dir sampled with cnt.

Reset
REQ-025 Reset assertion SHALL immediately force: state=ACQ, prev=4'b0001, miss_run=0, err_cnt=0, locked=0, fault=0, err=0, wrap_up=0, wrap_dn=0.
REQ-026 Reset mid-operation SHALL discard any in-progress sample; the first cnt_valid after deassertion SHALL be handled per ACQ rules.

Configuration
REQ-027 Macro ODD_CHK_WRAPCNT_EN defined: the block SHALL add output port wrap_cnt (8 bits), incremented modulo 256 on each wrap_up or wrap_dn pulse, reset to 0 and cleared by clr.
REQ-028 Macro ODD_CHK_WRAPCNT_EN undefined: the wrap_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then cnt=1, 3, 5 (dir=1), each valid -> locked=1 one cycle after the first sample; err never pulses; err_cnt=0.
REQ-030 LOCK with prev=15, dir=1, cnt=1 -> wrap_up=1 for one cycle; prev=1, dir=0, cnt=15 -> wrap_dn=1 (wrap_cnt=2 when the macro is defined).
REQ-031 LOCK with prev=5, dir=1, sample cnts 9, 3, 11 -> three err pulses, err_cnt=3, fault=1, locked=0; further samples leave err_cnt=3; clr -> fault=0, err_cnt=0, FSM in ACQ.
REQ-032 LOCK, cnt=4 -> err pulse, locked=0 (ACQ); next cnt=7 -> locked=1 with no err.
REQ-033 Force 256 rejections -> err_cnt=255 and held there; clr together with cnt_valid -> err_cnt=0 and no err pulse.
REQ-034 Assert reset between the clock edges of an active sample -> all outputs 0 immediately, err_cnt=0, FSM in ACQ.
